// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and the frame-length helper for uart_core.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE       = 3'd0,
    RX_START      = 3'd1,
    RX_DATA       = 3'd2,
    RX_PARITY     = 3'd3,
    RX_STOP       = 3'd4,
    RX_BREAK_WAIT = 3'd5
  } rx_state_t;

  // Bits per frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_core_rx.sv
// Receive half of uart_core: 2-FF line synchroniser and mid-bit sampling FSM
// with parity/framing checks and a break-wait state.
module uart_core_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_par_err;
  logic                 r_frame_err;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_rx_frame_err;
  logic                 r_rx_parity_err;
  logic                 r_rx_busy;

  logic w_rx;
  logic w_bit_end;
  logic w_half_end;
  logic w_frame_err;

  assign w_rx        = r_sync2;
  assign w_bit_end   = (r_cnt == CNT_LAST);
  assign w_half_end  = (r_cnt == HALF_LAST);
  assign w_frame_err = r_frame_err | ~w_rx;

  // Two-stage synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM; every sample after START is CLKS_PER_BIT from the start mid-point.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= RX_IDLE;
      r_cnt           <= '0;
      r_bit           <= '0;
      r_shift         <= '0;
      r_par           <= 1'b0;
      r_par_err       <= 1'b0;
      r_frame_err     <= 1'b0;
      r_rx_data       <= '0;
      r_rx_valid      <= 1'b0;
      r_rx_frame_err  <= 1'b0;
      r_rx_parity_err <= 1'b0;
      r_rx_busy       <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_cnt      <= r_cnt + CNT_W'(1'b1);
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (!w_rx) begin
            r_par       <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_busy   <= 1'b1;
            r_state     <= RX_START;
          end
        end
        RX_START: begin
          if (w_half_end) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_rx_busy <= 1'b0;
              r_state   <= RX_IDLE;
            end else begin
              r_state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
            r_par   <= r_par ^ w_rx;
            if (r_bit == DATA_LAST) begin
              r_bit <= '0;
              if (PARITY != PARITY_NONE) begin
                r_state <= RX_PARITY;
              end else begin
                r_state <= RX_STOP;
              end
            end else begin
              r_bit <= r_bit + BIT_W'(1'b1);
            end
          end
        end
        RX_PARITY: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_par_err <= r_par ^ w_rx ^ (PARITY == PARITY_ODD);
            r_state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == STOP_LAST) begin
              r_bit           <= '0;
              r_rx_valid      <= 1'b1;
              r_rx_data       <= r_shift;
              r_rx_frame_err  <= w_frame_err;
              r_rx_parity_err <= r_par_err;
              r_rx_busy       <= w_frame_err;
              // A low stop bit may be a break: wait for the line to recover first.
              if (w_frame_err) begin
                r_state <= RX_BREAK_WAIT;
              end else begin
                r_state <= RX_IDLE;
              end
            end else begin
              r_bit       <= r_bit + BIT_W'(1'b1);
              r_frame_err <= w_frame_err;
            end
          end
        end
        RX_BREAK_WAIT: begin
          r_cnt <= '0;
          if (w_rx) begin
            r_rx_busy <= 1'b0;
            r_state   <= RX_IDLE;
          end
        end
        default: begin
          r_cnt     <= '0;
          r_bit     <= '0;
          r_rx_busy <= 1'b0;
          r_state   <= RX_IDLE;
        end
      endcase
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_frame_err  = r_rx_frame_err;
  assign rx_parity_err = r_rx_parity_err;
  assign rx_busy       = r_rx_busy;

endmodule

// File: rtl/uart_core.sv
// Parametrised full-duplex UART: valid/ready transmit FSM inline, receive
// path in uart_core_rx. TX and RX share only clock and reset.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  tx_state_t            r_tx_state;
  logic [CNT_W-1:0]     r_tx_cnt;
  logic [BIT_W-1:0]     r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_uart_tx;
  logic                 r_tx_ready;
  logic                 r_tx_busy;
  logic                 w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == CNT_LAST);

  // Transmit FSM; uart_tx is registered so the start bit follows acceptance by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_uart_tx  <= 1'b1;
      r_tx_ready <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      if ((r_tx_state != TX_IDLE) && !w_tx_bit_end) begin
        r_tx_cnt <= r_tx_cnt + CNT_W'(1'b1);
      end else begin
        r_tx_cnt <= '0;
      end
      case (r_tx_state)
        TX_IDLE: begin
          r_tx_bit <= '0;
          if (tx_valid && r_tx_ready) begin
            r_tx_shift <= tx_data;
            r_tx_par   <= (PARITY == PARITY_EVEN) ? (^tx_data) : (~^tx_data);
            r_uart_tx  <= 1'b0;
            r_tx_ready <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            r_uart_tx  <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
            r_tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            if (r_tx_bit == DATA_LAST) begin
              r_tx_bit <= '0;
              if (PARITY != PARITY_NONE) begin
                r_uart_tx  <= r_tx_par;
                r_tx_state <= TX_PARITY;
              end else begin
                r_uart_tx  <= 1'b1;
                r_tx_state <= TX_STOP;
              end
            end else begin
              r_tx_bit   <= r_tx_bit + BIT_W'(1'b1);
              r_uart_tx  <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
            end
          end
        end
        TX_PARITY: begin
          if (w_tx_bit_end) begin
            r_uart_tx  <= 1'b1;
            r_tx_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (w_tx_bit_end) begin
            if (r_tx_bit == STOP_LAST) begin
              r_tx_bit   <= '0;
              r_tx_ready <= 1'b1;
              r_tx_busy  <= 1'b0;
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_bit <= r_tx_bit + BIT_W'(1'b1);
            end
          end
        end
        default: begin
          r_tx_bit   <= '0;
          r_uart_tx  <= 1'b1;
          r_tx_ready <= 1'b1;
          r_tx_busy  <= 1'b0;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign uart_tx  = r_uart_tx;
  assign tx_ready = r_tx_ready;
  assign tx_busy  = r_tx_busy;

  uart_core_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS),
    .PARITY       (PARITY),
    .STOP_BITS    (STOP_BITS)
  ) u_rx (
    .clk           (clk),
    .rst           (rst),
    .uart_rx       (uart_rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_busy       (rx_busy)
  );

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: three instances (8N1, 7O2 loopback, 8E1) at 16 clks/bit.
module tb_uart_core;
  import uart_pkg::*;

  localparam int CPB    = 16;
  localparam int FRAME1 = frame_bits(7, 2, 2) * CPB;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Instance 0: 8N1
  logic [7:0] tx_data0;
  logic       tx_valid0, rx_line0;
  logic       uart_tx0, tx_ready0, tx_busy0;
  logic [7:0] rx_data0;
  logic       rx_valid0, rx_frame_err0, rx_parity_err0, rx_busy0;
  // Instance 1: 7 data, odd parity, 2 stop, looped back
  logic [6:0] tx_data1;
  logic       tx_valid1;
  logic       uart_tx1, tx_ready1, tx_busy1;
  logic [6:0] rx_data1;
  logic       rx_valid1, rx_frame_err1, rx_parity_err1, rx_busy1;
  // Instance 2: 8 data, even parity, 1 stop, RX driven directly
  logic [7:0] tx_data2;
  logic       tx_valid2, rx_line2;
  logic       uart_tx2, tx_ready2, tx_busy2;
  logic [7:0] rx_data2;
  logic       rx_valid2, rx_frame_err2, rx_parity_err2, rx_busy2;

  int n_valid0, n_valid1, n_valid2;
  int v0;
  logic [9:0] exp_frame;

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .uart_rx(rx_line0), .uart_tx(uart_tx0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_busy(tx_busy0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_frame_err(rx_frame_err0),
    .rx_parity_err(rx_parity_err0), .rx_busy(rx_busy0)
  );

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .uart_rx(uart_tx1), .uart_tx(uart_tx1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_busy(tx_busy1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_frame_err(rx_frame_err1),
    .rx_parity_err(rx_parity_err1), .rx_busy(rx_busy1)
  );

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .uart_rx(rx_line2), .uart_tx(uart_tx2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_busy(tx_busy2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_frame_err(rx_frame_err2),
    .rx_parity_err(rx_parity_err2), .rx_busy(rx_busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rx_valid pulses per instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      n_valid0 <= n_valid0;
    end else begin
      n_valid0 <= n_valid0 + (rx_valid0 ? 1 : 0);
      n_valid1 <= n_valid1 + (rx_valid1 ? 1 : 0);
      n_valid2 <= n_valid2 + (rx_valid2 ? 1 : 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive n serial bits (LSB first) on RX line 0 or 2, CPB clocks each.
  task automatic drive_rx(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rx_line0 = bits[i];
      else          rx_line2 = bits[i];
      tick(CPB);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    n_valid0 = 0; n_valid1 = 0; n_valid2 = 0;
    rst = 1'b1;
    tx_data0 = 8'h00; tx_valid0 = 1'b0; rx_line0 = 1'b1;
    tx_data1 = 7'h00; tx_valid1 = 1'b0;
    tx_data2 = 8'h00; tx_valid2 = 1'b0; rx_line2 = 1'b1;
    tick(3);

    // Reset values
    check("rst_uart_tx0", uart_tx0, 1);
    check("rst_tx_ready0", tx_ready0, 1);
    check("rst_tx_busy0", tx_busy0, 0);
    check("rst_rx_valid0", rx_valid0, 0);
    check("rst_rx_data0", rx_data0, 0);
    check("rst_frame_err0", rx_frame_err0, 0);
    check("rst_parity_err0", rx_parity_err0, 0);
    check("rst_rx_busy0", rx_busy0, 0);
    check("rst_uart_tx1", uart_tx1, 1);
    check("rst_rx_busy1", rx_busy1, 0);
    check("rst_uart_tx2", uart_tx2, 1);
    check("rst_tx_ready2", tx_ready2, 1);
    check("rst_tx_busy2", tx_busy2, 0);
    check("rst_rx_busy2", rx_busy2, 0);
    rst = 1'b0;
    tick(2);

    // TX 0x55 on 8N1: start one clk after accept, LSB first, 16 clks per bit
    check("tx55_ready_before", tx_ready0, 1);
    tx_data0 = 8'h55; tx_valid0 = 1'b1;
    tick(1);
    tx_valid0 = 1'b0; tx_data0 = 8'hFF;
    check("tx55_ready_low", tx_ready0, 0);
    check("tx55_busy", tx_busy0, 1);
    exp_frame = {1'b1, 8'h55, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      check($sformatf("tx55_line_c%0d", c), uart_tx0, exp_frame[c / CPB]);
      tick(1);
    end
    check("tx55_ready_back", tx_ready0, 1);
    check("tx55_busy_done", tx_busy0, 0);
    check("tx55_idle_line", uart_tx0, 1);

    // Loopback 7O2: 0x41 then 0x2A back-to-back with tx_valid held
    tx_data1 = 7'h41; tx_valid1 = 1'b1;
    tick(1);
    tx_data1 = 7'h2A;
    check("lb_start1", uart_tx1, 0);
    check("lb_ready_low", tx_ready1, 0);
    tick(136);
    check("lb_parity_bit", uart_tx1, 1);
    tick(FRAME1 - 136);
    check("lb_valid_count1", n_valid1, 1);
    check("lb_rx_data1", rx_data1, 7'h41);
    check("lb_frame_err1", rx_frame_err1, 0);
    check("lb_parity_err1", rx_parity_err1, 0);
    check("lb_ready_gap", tx_ready1, 1);
    check("lb_line_gap", uart_tx1, 1);
    tick(1);
    tx_valid1 = 1'b0;
    check("lb_start2", uart_tx1, 0);
    check("lb_ready_low2", tx_ready1, 0);
    tick(FRAME1 + 2);
    check("lb_valid_count2", n_valid1, 2);
    check("lb_rx_data2", rx_data1, 7'h2A);
    check("lb_frame_err2", rx_frame_err1, 0);
    check("lb_parity_err2", rx_parity_err1, 0);
    check("lb_tx_busy_done", tx_busy1, 0);
    check("lb_rx_busy_done", rx_busy1, 0);

    // Even parity: 0x03 with a wrong parity bit of 1
    drive_rx(2, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    tick(4);
    check("par_valid_count", n_valid2, 1);
    check("par_rx_data", rx_data2, 8'h03);
    check("par_parity_err", rx_parity_err2, 1);
    check("par_frame_err", rx_frame_err2, 0);
    check("par_rx_busy", rx_busy2, 0);

    // Framing error followed by a held-low break, then a clean frame
    v0 = n_valid0;
    drive_rx(0, 16'h0000, 10);
    tick(5 * CPB);
    check("brk_one_pulse", n_valid0, v0 + 1);
    check("brk_frame_err", rx_frame_err0, 1);
    check("brk_rx_data", rx_data0, 8'h00);
    check("brk_parity_err", rx_parity_err0, 0);
    check("brk_busy_wait", rx_busy0, 1);
    rx_line0 = 1'b1;
    tick(6);
    check("brk_released", rx_busy0, 0);
    check("brk_no_extra", n_valid0, v0 + 1);
    drive_rx(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
    tick(4);
    check("brk_next_count", n_valid0, v0 + 2);
    check("brk_next_data", rx_data0, 8'hA5);
    check("brk_next_ferr", rx_frame_err0, 0);

    // Glitch: 3-clk low pulse must not start a frame
    v0 = n_valid0;
    rx_line0 = 1'b0;
    tick(3);
    rx_line0 = 1'b1;
    check("glitch_busy", rx_busy0, 1);
    tick(CPB / 2);
    check("glitch_rearm", rx_busy0, 0);
    tick(10);
    check("glitch_no_pulse", n_valid0, v0);

    // Reset during TX data bit 3 and RX data bit 4
    v0 = n_valid0;
    tx_data0 = 8'h00; tx_valid0 = 1'b1; rx_line0 = 1'b0;
    tick(1);
    tx_valid0 = 1'b0;
    tick(76);
    check("mid_tx_line", uart_tx0, 0);
    check("mid_tx_busy", tx_busy0, 1);
    check("mid_rx_busy", rx_busy0, 1);
    rst = 1'b1; rx_line0 = 1'b1;
    tick(1);
    check("mid_rst_uart_tx", uart_tx0, 1);
    check("mid_rst_tx_ready", tx_ready0, 1);
    check("mid_rst_tx_busy", tx_busy0, 0);
    check("mid_rst_rx_busy", rx_busy0, 0);
    check("mid_rst_rx_data", rx_data0, 8'h00);
    rst = 1'b0;
    tick(200);
    check("mid_no_pulse", n_valid0, v0);
    check("mid_rx_idle", rx_busy0, 0);
    check("mid_tx_idle", uart_tx0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
